// File: rtl/counter_bank_sched.sv
// Bank of N_CNT counters sharing one incrementer through a round-robin arbiter.
// Provides a priority load port, per-counter MSB/wrap outputs and a registered read-back port.
module counter_bank_sched #(
    parameter int unsigned N_CNT = 8,
    parameter int unsigned WIDTH = 22,
    localparam int unsigned SelW = $clog2(N_CNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CNT-1:0] req,
    input  logic             load_valid,
    input  logic [SelW-1:0]  load_sel,
    input  logic [WIDTH-1:0] load_value,
    input  logic [SelW-1:0]  rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [N_CNT-1:0] grant,
    output logic [N_CNT-1:0] wrap,
    output logic [N_CNT-1:0] count_msb
);

    logic [WIDTH-1:0] cnt_q [N_CNT];
    logic [WIDTH-1:0] cnt_d [N_CNT];
    logic [SelW-1:0]  ptr_q, ptr_d;
    logic [N_CNT-1:0] grant_q, grant_d;
    logic [N_CNT-1:0] wrap_q, wrap_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             win_valid;
    logic [SelW-1:0]  win_idx;
    logic [SelW:0]    scan_idx;
    logic [WIDTH-1:0] win_cnt;
    logic [WIDTH-1:0] win_inc;
    logic             load_hit;

    // Scan ptr, ptr+1, ... wrapping at N_CNT; the first asserted request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_CNT; i++) begin
            scan_idx = {1'b0, ptr_q} + (SelW + 1)'(i);
            if (scan_idx >= (SelW + 1)'(N_CNT)) begin
                scan_idx = scan_idx - (SelW + 1)'(N_CNT);
            end
            if (!win_valid && req[scan_idx[SelW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx[SelW-1:0];
            end
        end
    end

    assign win_cnt  = cnt_q[win_idx];
    assign win_inc  = win_cnt + WIDTH'(1);
    assign load_hit = load_valid && (32'(load_sel) < N_CNT);

    always_comb begin
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        wrap_d  = '0;
        if (load_hit) begin
            cnt_d[load_sel] = load_value;
        end else if (win_valid) begin
            cnt_d[win_idx]   = win_inc;
            grant_d[win_idx] = 1'b1;
            wrap_d[win_idx]  = &win_cnt;
            ptr_d            = (win_idx == SelW'(N_CNT - 1)) ? '0 : win_idx + SelW'(1);
        end
    end

    // Read-back samples the pre-update value of the selected counter.
    always_comb begin
        rd_data_d = '0;
        if (32'(rd_sel) < N_CNT) begin
            rd_data_d = cnt_q[rd_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '{default: '0};
            ptr_q     <= '0;
            grant_q   <= '0;
            wrap_q    <= '0;
            rd_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            wrap_q    <= wrap_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        count_msb = '0;
        for (int i = 0; i < N_CNT; i++) begin
            count_msb[i] = cnt_q[i][WIDTH-1];
        end
    end

    assign grant   = grant_q;
    assign wrap    = wrap_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_counter_bank_sched.sv
// Randomized and directed bench for counter_bank_sched; a reference model pushes expected
// outputs into a queue and an independent monitor compares them after each clock edge.
module tb_counter_bank_sched;

    localparam int N = 8;
    localparam int W = 22;
    localparam int SW = 3;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] wrap;
        logic [W-1:0] rd;
        logic [N-1:0] msb;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic          load_valid = 1'b0;
    logic [SW-1:0] load_sel = '0;
    logic [W-1:0]  load_value = '0;
    logic [SW-1:0] rd_sel = '0;
    logic [W-1:0]  rd_data;
    logic [N-1:0]  grant;
    logic [N-1:0]  wrap;
    logic [N-1:0]  count_msb;

    counter_bank_sched #(.N_CNT(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .load_valid (load_valid),
        .load_sel   (load_sel),
        .load_value (load_value),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .grant      (grant),
        .wrap       (wrap),
        .count_msb  (count_msb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];

    // Behavioural model: plain integers, modulo arithmetic.
    longint m_cnt [N];
    int     m_ptr = 0;
    localparam longint Mod = longint'(1) << W;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input logic r, input logic [N-1:0] rq, input logic lv,
                                        input int ls, input longint lval, input int rs);
        exp_t e;
        int win;
        e.grant = '0;
        e.wrap  = '0;
        e.rd    = '0;
        if (r) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_ptr = 0;
        end else begin
            e.rd = (rs < N) ? W'(m_cnt[rs]) : '0;
            if (lv && ls < N) begin
                m_cnt[ls] = lval;
            end else begin
                win = -1;
                for (int off = 0; off < N; off++) begin
                    if (win < 0 && rq[(m_ptr + off) % N]) win = (m_ptr + off) % N;
                end
                if (win >= 0) begin
                    e.grant[win] = 1'b1;
                    e.wrap[win]  = (m_cnt[win] == Mod - 1);
                    m_cnt[win]   = (m_cnt[win] + 1) % Mod;
                    m_ptr        = (win + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) e.msb[i] = (m_cnt[i] >= Mod / 2);
        return e;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] rq, input logic lv, input int ls,
                        input longint lval, input int rs);
        @(negedge clk);
        rst        = r;
        req        = rq;
        load_valid = lv;
        load_sel   = SW'(ls);
        load_value = W'(lval);
        rd_sel     = SW'(rs);
        sb_q.push_back(model_step(r, rq, lv, ls, lval, rs));
    endtask

    task automatic idle(input int rs);
        step(1'b0, '0, 1'b0, 0, 0, rs);
    endtask

    // Monitor: outputs are presented every cycle, so each edge retires one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("grant", grant, e.grant);
                chk("wrap", wrap, e.wrap);
                chk("rd_data", rd_data, e.rd);
                chk("count_msb", count_msb, e.msb);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset with requests and a load pending.
        step(1'b1, 8'hFF, 1'b1, 2, 123, 0);
        step(1'b1, 8'hFF, 1'b1, 2, 123, 0);
        idle(2);
        idle(2);

        // Single requester, five grants.
        repeat (5) step(1'b0, 8'h01, 1'b0, 0, 0, 0);
        idle(0);
        idle(0);
        @(posedge clk);
        #2;
        chk("single_rd5", rd_data, 5);

        // Fair rotation from reset.
        step(1'b1, '0, 1'b0, 0, 0, 0);
        repeat (16) step(1'b0, 8'hFF, 1'b0, 0, 0, 0);
        for (int i = 0; i < N; i++) idle(i);
        idle(0);

        // Wrap of counter 3.
        step(1'b0, '0, 1'b1, 3, 22'h3FFFFF, 3);
        step(1'b0, 8'h08, 1'b0, 0, 0, 3);
        @(posedge clk);
        #2;
        chk("wrap_pulse", wrap, 8'h08);
        idle(3);
        @(posedge clk);
        #2;
        chk("wrap_clear", wrap, 0);

        // Load beats increment; ptr holds at 2.
        step(1'b1, '0, 1'b0, 0, 0, 0);
        step(1'b0, 8'h02, 1'b0, 0, 0, 0);
        step(1'b0, 8'h04, 1'b1, 2, 100, 2);
        @(posedge clk);
        #2;
        chk("collide_grant", grant, 0);
        step(1'b0, 8'h04, 1'b0, 0, 0, 2);
        idle(2);
        idle(2);
        @(posedge clk);
        #2;
        chk("collide_rd101", rd_data, 101);

        // Skip: ptr=1 with requesters 7 and 0.
        step(1'b1, '0, 1'b0, 0, 0, 0);
        step(1'b0, 8'h01, 1'b0, 0, 0, 0);
        repeat (4) step(1'b0, 8'h81, 1'b0, 0, 0, 7);
        idle(0);

        // Randomized traffic, near-wrap loads to provoke wraps.
        for (int c = 0; c < 600; c++) begin
            logic r, lv;
            logic [N-1:0] rq;
            longint lval;
            r    = ($urandom_range(0, 99) == 0);
            lv   = ($urandom_range(0, 7) == 0);
            rq   = N'($urandom) & N'($urandom);
            lval = ($urandom_range(0, 1) == 0) ? Mod - 1 - longint'($urandom_range(0, 3))
                                              : longint'($urandom) % Mod;
            step(r, rq, lv, int'($urandom_range(0, N - 1)), lval,
                 int'($urandom_range(0, N - 1)));
        end
        idle(0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
